// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator and its voice slots.
package midi_pkg;

    localparam int unsigned NOTE_W    = 7;
    localparam int unsigned CHAN_W    = 4;
    localparam int unsigned VEL_W     = 7;
    localparam int unsigned AGE_MAX_W = 16;

    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;

    // Age field is sized for the largest supported AGE_W; slots saturate below it.
    typedef struct packed {
        logic                 gate;
        logic [CHAN_W-1:0]    chan;
        logic [NOTE_W-1:0]    note;
        logic [VEL_W-1:0]     vel;
        logic [AGE_MAX_W-1:0] age;
    } voice_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_RETRIG,
        CMD_RELEASE,
        CMD_AGE
    } slot_cmd_t;

endpackage

// File: rtl/midi_voice_slot.sv
// One voice slot: holds a voice_t and executes load/retrigger/release/age commands.
module midi_voice_slot
    import midi_pkg::*;
#(
    parameter int unsigned AGE_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  slot_cmd_t         cmd,
    input  logic [CHAN_W-1:0] ld_chan,
    input  logic [NOTE_W-1:0] ld_note,
    input  logic [VEL_W-1:0]  ld_vel,
    output voice_t            voice,
    output logic              upd
);

    localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((64'd1 << AGE_W) - 64'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            voice <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= (cmd == CMD_LOAD) || (cmd == CMD_RETRIG) || (cmd == CMD_RELEASE);
            case (cmd)
                CMD_LOAD: begin
                    voice.gate <= 1'b1;
                    voice.chan <= ld_chan;
                    voice.note <= ld_note;
                    voice.vel  <= ld_vel;
                    voice.age  <= '0;
                end
                CMD_RETRIG: begin
                    voice.vel <= ld_vel;
                    voice.age <= '0;
                end
                CMD_RELEASE: voice.gate <= 1'b0;
                CMD_AGE: begin
                    if (voice.age != AGE_SAT) voice.age <= voice.age + AGE_MAX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: retrigger match, else free voice, else steal/drop.
// Build option MIDI_VOICE_STEAL_EN: steal the oldest voice instead of dropping on a full pool.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         msg_valid,
    output logic                         msg_ready,
    input  logic                         msg_on,
    input  logic [CHAN_W-1:0]            msg_chan,
    input  logic [NOTE_W-1:0]            msg_note,
    input  logic [VEL_W-1:0]             msg_vel,
    input  logic [1:0]                   control_in,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
    output logic [NUM_VOICES-1:0]        voice_upd,
    output logic                         irq,
    output logic [7:0]                   steal_cnt
);

    localparam int unsigned        IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t      state_q, state_d;
    logic              msg_ready_q;
    logic [3:0]        status_q;
    logic [CHAN_W-1:0] chan_q;
    logic [NOTE_W-1:0] note_q;
    logic [VEL_W-1:0]  vel_q;
    logic [IDX_W-1:0]  scan_idx_q;
    logic              match_q, free_q;
    logic [IDX_W-1:0]  match_idx_q, free_idx_q;
    logic              irq_q;
    logic [7:0]        steal_cnt_q;

    voice_t            voices [NUM_VOICES];
    slot_cmd_t         cmds   [NUM_VOICES];
    voice_t            cur_c;
    logic              accept_c, note_on_c, steal_evt_c, age_all_c;
    logic [IDX_W-1:0]  tgt_c;
    slot_cmd_t         tgt_cmd_c;

    assign accept_c  = (state_q == IDLE) && msg_valid && msg_ready_q;
    assign cur_c     = voices[scan_idx_q];
    assign note_on_c = (status_q == STATUS_NOTE_ON) && (vel_q != '0);

`ifdef MIDI_VOICE_STEAL_EN
    logic [IDX_W-1:0]     old_idx_q;
    logic [AGE_MAX_W-1:0] old_age_q;
`else
    logic [NUM_VOICES-1:0] unused_age_par;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and the commit decision for the latched message.
    always_comb begin
        state_d     = state_q;
        tgt_c       = '0;
        tgt_cmd_c   = CMD_NONE;
        age_all_c   = 1'b0;
        steal_evt_c = 1'b0;
        case (state_q)
            IDLE: if (accept_c) state_d = SCAN;
            SCAN: if (scan_idx_q == LAST_IDX) state_d = COMMIT;
            COMMIT: begin
                state_d = IDLE;
                if (note_on_c) begin
                    if (match_q) begin
                        tgt_c     = match_idx_q;
                        tgt_cmd_c = CMD_RETRIG;
                        age_all_c = 1'b1;
                    end else if (free_q) begin
                        tgt_c     = free_idx_q;
                        tgt_cmd_c = CMD_LOAD;
                        age_all_c = 1'b1;
                    end else begin
                        steal_evt_c = 1'b1;
`ifdef MIDI_VOICE_STEAL_EN
                        tgt_c     = old_idx_q;
                        tgt_cmd_c = CMD_LOAD;
                        age_all_c = 1'b1;
`endif
                    end
                end else if (match_q) begin
                    tgt_c     = match_idx_q;
                    tgt_cmd_c = CMD_RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The touched voice gets the command; every other gated voice ages.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            cmds[i] = CMD_NONE;
            if (tgt_cmd_c != CMD_NONE && tgt_c == IDX_W'(i)) cmds[i] = tgt_cmd_c;
            else if (age_all_c && voices[i].gate)            cmds[i] = CMD_AGE;
        end
    end

    // Message latch and per-cycle scan bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            msg_ready_q <= 1'b0;
            status_q    <= '0;
            chan_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            scan_idx_q  <= '0;
            match_q     <= 1'b0;
            free_q      <= 1'b0;
            match_idx_q <= '0;
            free_idx_q  <= '0;
`ifdef MIDI_VOICE_STEAL_EN
            old_idx_q   <= '0;
            old_age_q   <= '0;
`endif
        end else begin
            msg_ready_q <= (state_d == IDLE);
            if (accept_c) begin
                status_q    <= msg_on ? STATUS_NOTE_ON : STATUS_NOTE_OFF;
                chan_q      <= msg_chan;
                note_q      <= msg_note;
                vel_q       <= msg_vel;
                scan_idx_q  <= '0;
                match_q     <= 1'b0;
                free_q      <= 1'b0;
                match_idx_q <= '0;
                free_idx_q  <= '0;
`ifdef MIDI_VOICE_STEAL_EN
                old_idx_q   <= '0;
                old_age_q   <= '0;
`endif
            end else if (state_q == SCAN) begin
                scan_idx_q <= scan_idx_q + IDX_W'(1);
                if (!match_q && cur_c.gate && cur_c.chan == chan_q && cur_c.note == note_q) begin
                    match_q     <= 1'b1;
                    match_idx_q <= scan_idx_q;
                end
                if (!free_q && !cur_c.gate) begin
                    free_q     <= 1'b1;
                    free_idx_q <= scan_idx_q;
                end
`ifdef MIDI_VOICE_STEAL_EN
                // Strict compare keeps the lowest index on equal ages.
                if (cur_c.age > old_age_q) begin
                    old_age_q <= cur_c.age;
                    old_idx_q <= scan_idx_q;
                end
`endif
            end
        end
    end

    // Sticky interrupt (set beats clear) and saturating steal/drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_q       <= 1'b0;
            steal_cnt_q <= '0;
        end else begin
            if (steal_evt_c && control_in[0]) irq_q <= 1'b1;
            else if (control_in[1])           irq_q <= 1'b0;
            if (steal_evt_c && steal_cnt_q != 8'hFF) steal_cnt_q <= steal_cnt_q + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        midi_voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk     (clk),
            .rstn    (rstn),
            .cmd     (cmds[g]),
            .ld_chan (chan_q),
            .ld_note (note_q),
            .ld_vel  (vel_q),
            .voice   (voices[g]),
            .upd     (voice_upd[g])
        );
        assign voice_gate[g]                 = voices[g].gate;
        assign voice_note[g*NOTE_W +: NOTE_W] = voices[g].note;
        assign voice_vel[g*VEL_W +: VEL_W]    = voices[g].vel;
`ifndef MIDI_VOICE_STEAL_EN
        assign unused_age_par[g] = ^voices[g].age;
`endif
    end

    assign msg_ready = msg_ready_q;
    assign irq       = irq_q;
    assign steal_cnt = steal_cnt_q;

endmodule
